// File: rtl/saw_pkg.sv
// Shared Stop-and-Wait definitions: state codes, action-strobe bit positions
// and the default sequence-number width (also used by the transmitter).
package saw_pkg;

   localparam int SEQ_W_DEF = 1;

   localparam int OUT_EXTRACT = 3;
   localparam int OUT_DELIVER = 2;
   localparam int OUT_ACK     = 1;
   localparam int OUT_DISCARD = 0;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_EXTRACT = 3'd1,
      S_DELIVER = 3'd2,
      S_ACK     = 3'd3,
      S_DUP     = 3'd4,
      S_DISCARD = 3'd5
   } saw_state_t;

endpackage

// File: rtl/saw_sat_counter.sv
// Saturating up-counter used for the receiver statistics; sticks at all ones.
module saw_sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         cnt <= '0;
      else if (inc && (cnt != {CNT_W{1'b1}}))
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/saw_receiver_fsm.sv
// Stop-and-Wait ARQ receiver: accepts in-order frames, delivers them to the
// network layer, ACKs with the next expected number and re-ACKs duplicates.
module saw_receiver_fsm
   import saw_pkg::*;
#(
   parameter int SEQ_W  = SEQ_W_DEF,
   parameter int OUT_BW = 4,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              frame_valid,
   input  logic              frame_err,
   input  logic [SEQ_W-1:0]  frame_seq,
   input  logic              deliver_ready,
   output logic [2:0]        state,
   output logic [OUT_BW-1:0] out,
   output logic [SEQ_W-1:0]  ack_seq,
   output logic [SEQ_W-1:0]  rn,
   output logic [CNT_W-1:0]  good_cnt,
   output logic [CNT_W-1:0]  dup_cnt,
   output logic [CNT_W-1:0]  err_cnt
);

   saw_state_t state_q;
   logic       inc_good, inc_dup, inc_err;
   logic       idle_take;

   assign state     = state_q;
   // Frames are only sampled in idle; anything arriving elsewhere is dropped.
   assign idle_take = (state_q == S_IDLE) && frame_valid;
   assign inc_err   = idle_take && frame_err;
   assign inc_dup   = idle_take && !frame_err && (frame_seq != rn);
   assign inc_good  = (state_q == S_DELIVER) && deliver_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         rn      <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (frame_valid) begin
                  if (frame_err)
                     state_q <= S_DISCARD;
                  else if (frame_seq == rn)
                     state_q <= S_EXTRACT;
                  else
                     state_q <= S_DUP;
               end
            end
            S_EXTRACT: state_q <= S_DELIVER;
            S_DELIVER: begin
               if (deliver_ready) begin
                  rn      <= rn + 1'b1;
                  state_q <= S_ACK;
               end
            end
            S_ACK, S_DUP, S_DISCARD: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Moore decode from the state register, so reset forces every strobe low.
   always_comb begin
      out     = '0;
      ack_seq = '0;
      case (state_q)
         S_EXTRACT: out[OUT_EXTRACT] = 1'b1;
         S_DELIVER: out[OUT_DELIVER] = 1'b1;
         S_ACK: begin
            out[OUT_ACK] = 1'b1;
            ack_seq      = rn;
         end
         S_DUP: begin
            out[OUT_ACK]     = 1'b1;
            out[OUT_DISCARD] = 1'b1;
            ack_seq          = rn;
         end
         S_DISCARD: out[OUT_DISCARD] = 1'b1;
         default: ;
      endcase
   end

   saw_sat_counter #(.CNT_W(CNT_W)) u_good (.clk(clk), .rstn(rstn), .inc(inc_good), .cnt(good_cnt));
   saw_sat_counter #(.CNT_W(CNT_W)) u_dup  (.clk(clk), .rstn(rstn), .inc(inc_dup),  .cnt(dup_cnt));
   saw_sat_counter #(.CNT_W(CNT_W)) u_err  (.clk(clk), .rstn(rstn), .inc(inc_err),  .cnt(err_cnt));

endmodule

// File: tb/tb_saw_receiver_fsm.sv
// Directed bench for saw_receiver_fsm: default build plus a SEQ_W=2/CNT_W=2 build.
module tb_saw_receiver_fsm;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   always #5 clk = ~clk;

   // default instance: SEQ_W=1, CNT_W=8
   logic       fv = 1'b0, fe = 1'b0, dr = 1'b1;
   logic [0:0] fs = '0;
   logic [2:0] st;
   logic [3:0] out;
   logic [0:0] ack, rn;
   logic [7:0] gc, dc, ec;

   // wide-sequence, narrow-counter instance
   logic       fv2 = 1'b0, fe2 = 1'b0, dr2 = 1'b1;
   logic [1:0] fs2 = '0;
   logic [2:0] st2;
   logic [3:0] out2;
   logic [1:0] ack2, rn2;
   logic [1:0] gc2, dc2, ec2;

   int vectors = 0;
   int miscompares = 0;

   saw_receiver_fsm dut (
      .clk(clk), .rstn(rstn), .frame_valid(fv), .frame_err(fe), .frame_seq(fs),
      .deliver_ready(dr), .state(st), .out(out), .ack_seq(ack), .rn(rn),
      .good_cnt(gc), .dup_cnt(dc), .err_cnt(ec));

   saw_receiver_fsm #(.SEQ_W(2), .CNT_W(2)) dut2 (
      .clk(clk), .rstn(rstn), .frame_valid(fv2), .frame_err(fe2), .frame_seq(fs2),
      .deliver_ready(dr2), .state(st2), .out(out2), .ack_seq(ack2), .rn(rn2),
      .good_cnt(gc2), .dup_cnt(dc2), .err_cnt(ec2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulse one frame; returns at the negedge where the post-sample state shows.
   task automatic send(input logic err, input logic [0:0] seq);
      @(negedge clk);
      fv = 1'b1; fe = err; fs = seq;
      @(negedge clk);
      fv = 1'b0; fe = 1'b0;
   endtask

   task automatic send2(input logic err, input logic [1:0] seq);
      @(negedge clk);
      fv2 = 1'b1; fe2 = err; fs2 = seq;
      @(negedge clk);
      fv2 = 1'b0; fe2 = 1'b0;
   endtask

   task automatic good_frame(input string tag, input logic [0:0] seq, input logic [0:0] exp_ack);
      send(1'b0, seq);
      chk({tag, "_extract"}, out, 4'b1000);
      @(negedge clk);
      chk({tag, "_deliver"}, out, 4'b0100);
      @(negedge clk);
      chk({tag, "_ack"}, out, 4'b0010);
      chk({tag, "_ackseq"}, ack, exp_ack);
      @(negedge clk);
      chk({tag, "_idle"}, out, 4'b0000);
   endtask

   initial begin
      #12;
      chk("rst_state", st, 3'd0);
      chk("rst_rn", rn, 1'b0);
      chk("rst_out", out, 4'b0000);
      chk("rst_ack", ack, 1'b0);
      chk("rst_cnts", {gc, dc, ec}, 24'h0);
      rstn = 1'b1;

      // first good frame, then alternating sequence numbers
      good_frame("g0", 1'b0, 1'b1);
      chk("g0_rn", rn, 1'b1);
      chk("g0_good", gc, 8'd1);
      good_frame("g1", 1'b1, 1'b0);
      chk("g1_rn", rn, 1'b0);
      good_frame("g2", 1'b0, 1'b1);
      chk("g2_rn", rn, 1'b1);
      chk("g2_good", gc, 8'd3);

      // duplicate of seq0 while expecting 1
      send(1'b0, 1'b0);
      chk("dup_out", out, 4'b0011);
      chk("dup_ackseq", ack, 1'b1);
      chk("dup_state", st, 3'd4);
      @(negedge clk);
      chk("dup_idle", out, 4'b0000);
      chk("dup_rn", rn, 1'b1);
      chk("dup_cnt", dc, 8'd1);
      chk("dup_good", gc, 8'd3);

      // corrupt frame carrying the expected number
      send(1'b1, 1'b1);
      chk("err_out", out, 4'b0001);
      chk("err_ackseq", ack, 1'b0);
      @(negedge clk);
      chk("err_idle", out, 4'b0000);
      chk("err_cnt", ec, 8'd1);
      chk("err_rn", rn, 1'b1);

      // network layer stalls for 5 cycles; a stray frame arrives meanwhile
      dr = 1'b0;
      send(1'b0, 1'b1);
      chk("stall_extract", out, 4'b1000);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("stall_hold%0d", i), out, 4'b0100);
         fv = (i == 1); fe = (i == 1);
      end
      fv = 1'b0; fe = 1'b0;
      chk("stall_cnts", {gc, dc, ec}, {8'd3, 8'd1, 8'd1});
      dr = 1'b1;
      @(negedge clk);
      chk("stall_ack", out, 4'b0010);
      chk("stall_ackseq", ack, 1'b0);
      @(negedge clk);
      chk("stall_idle", out, 4'b0000);
      chk("stall_good", gc, 8'd4);
      chk("stall_rn", rn, 1'b0);

      // asynchronous reset while stuck in deliver
      dr = 1'b0;
      send(1'b0, 1'b0);
      @(negedge clk);
      chk("ar_pre", st, 3'd2);
      #2 rstn = 1'b0;
      #1;
      chk("ar_state", st, 3'd0);
      chk("ar_out", out, 4'b0000);
      chk("ar_rn", rn, 1'b0);
      chk("ar_cnts", {gc, dc, ec}, 24'h0);
      @(negedge clk);
      rstn = 1'b1;
      dr = 1'b1;

      // SEQ_W=2: four good frames wrap rn 0->1->2->3->0
      for (int i = 0; i < 4; i++) begin
         send2(1'b0, 2'(i));
         chk($sformatf("w%0d_extract", i), out2, 4'b1000);
         @(negedge clk);
         @(negedge clk);
         chk($sformatf("w%0d_ackseq", i), ack2, 32'((i + 1) % 4));
         @(negedge clk);
         chk($sformatf("w%0d_rn", i), rn2, 32'((i + 1) % 4));
      end
      chk("w_good", gc2, 2'd3);

      // CNT_W=2: five corrupt frames saturate err_cnt at 3
      for (int i = 0; i < 5; i++) begin
         send2(1'b1, 2'd0);
         chk($sformatf("sat%0d_out", i), out2, 4'b0001);
         @(negedge clk);
      end
      chk("sat_err", ec2, 2'd3);
      chk("sat_rn", rn2, 2'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/saw_receiver_fsm.md
Name: saw_receiver_fsm

Overview:
- Receiver end of the Stop-and-Wait ARQ link; pairs with the SAW transmitter FSM.
- Checks each arriving frame for errors and sequence number, and extracts and delivers in-order frames to the network layer.
- Sends a numbered ACK for each delivered frame and re-ACKs duplicates; corrupted frames are discarded silently so the transmitter's timeout forces a resend.
- Sits between the physical/error-check stage and the network layer.

Parameters:
SEQ_W, 1, sequence-number width; R_n counts modulo 2^SEQ_W (1 = classic SAW)
OUT_BW, 4, width of the action strobe bus out
CNT_W, 8, width of each saturating statistics counter

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
frame_valid  input  1  a frame is present this cycle (single-cycle pulse)
frame_err  input  1  frame failed error check; qualified by frame_valid
frame_seq  input  SEQ_W  sequence number of the arriving frame; qualified by frame_valid
deliver_ready  input  1  network layer accepts the delivered packet
state  output  3  current FSM state (debug/observation)
out  output  OUT_BW  action strobes {extract, deliver, send_ack, discard}, bit3..bit0
ack_seq  output  SEQ_W  ACK number; valid only while out[1] (send_ack)=1, otherwise 0
rn  output  SEQ_W  expected sequence number R_n
good_cnt  output  CNT_W  frames delivered
dup_cnt  output  CNT_W  duplicate frames received
err_cnt  output  CNT_W  corrupted frames discarded

Behaviour:
- Clock and reset: one clock, clk. rstn is asynchronous, active-low.
- Reset state: state=S_IDLE, rn=0, all counters=0, out=0, ack_seq=0.
- Reset mid-operation aborts any pending delivery; no strobe may glitch high during reset.
- Outputs (out, ack_seq) are Moore outputs decoded from the registered state. state, rn and the counters are registers.
- State encodings: S_IDLE=0, S_EXTRACT=1, S_DELIVER=2, S_ACK=3, S_DUP=4, S_DISCARD=5. Codes 6-7 are illegal and go to S_IDLE with out=0.
- S_IDLE, out=0000. Sample the frame inputs at the edge where frame_valid=1. Priority:
  - frame_err=1 -> S_DISCARD, err_cnt+1. frame_seq is ignored.
  - else frame_seq==rn -> S_EXTRACT.
  - else -> S_DUP, dup_cnt+1.
  - frame_valid=0 -> stay in S_IDLE.
- S_EXTRACT, out=1000: one cycle, then S_DELIVER.
- S_DELIVER, out=0100: hold while deliver_ready=0 (no timeout). At the edge where deliver_ready=1: rn<=rn+1 (wraps to 0 at 2^SEQ_W-1), good_cnt+1, go to S_ACK.
- S_ACK, out=0010, ack_seq=rn (already incremented, i.e. next expected): one cycle, then S_IDLE.
- S_DUP, out=0011, ack_seq=rn (unchanged): re-ACKs the frame the receiver has already delivered. One cycle, then S_IDLE. rn is not modified.
- S_DISCARD, out=0001, no ACK: one cycle, then S_IDLE.
- frame_valid in any state other than S_IDLE is dropped: no state change, no counter change. Upstream guarantees spacing; the bench checks the drop.
- Latency, good frame with deliver_ready held at 1:
  - valid sampled at edge E0;
  - extract during cycle 1;
  - deliver during cycle 2;
  - send_ack during cycle 3;
  - back in S_IDLE at cycle 4, where it can accept the next frame.
- Duplicate or corrupt frame: one cycle in S_DUP or S_DISCARD, then back to S_IDLE.
- Counters saturate at all ones and never wrap. Each counter increments at most once per frame.

Decomposition:
- Shared package saw_pkg, also used by the transmitter:
  - state encoding constants;
  - out-bit index constants (OUT_EXTRACT=3, OUT_DELIVER=2, OUT_ACK=1, OUT_DISCARD=0);
  - default SEQ_W.
- Sub-module saw_sat_counter: parameterised by CNT_W; inputs clk, rstn, inc; output cnt. Instantiated three times.

Test Plan:
- Reset, then a good frame with frame_seq=0 and deliver_ready=1 -> out sequence 1000, 0100, 0010 (ack_seq=1), then 0000; rn=1, good_cnt=1.
- Frames with frame_seq=0,1,0 in turn -> ack_seq=1,0,1 and rn ends at 1; with SEQ_W=2, four good frames wrap rn 0→1→2→3→0.
- After seq0 is delivered (rn=1), resend seq0 -> out=0011 with ack_seq=1 for one cycle; rn stays 1, dup_cnt=1, no deliver strobe.
- Frame with frame_err=1 and frame_seq=rn -> out=0001 for one cycle, no ACK, err_cnt=1, rn unchanged.
- deliver_ready held at 0 for 5 cycles -> out=0100 held for 5 cycles; a frame_valid pulse arriving meanwhile is ignored (counters unchanged); ACK follows the cycle after deliver_ready rises.
- rstn asserted asynchronously while in S_DELIVER -> state=0, rn=0 and counters=0 immediately; with CNT_W=2, five corrupt frames give err_cnt saturated at 3.
